// File: rtl/channelizer_pkg.sv
// Shared widths, FSM state and bin-window helper for the channelizer return path.
package channelizer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BIN_W  = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FCNT_W = 16;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BIN_W-1:0]  bin;
    logic              last;
    logic              eob;
  } beat_t;

  // Window test with modular wrap, so a window may straddle bin 2^BIN_W-1 -> 0.
  function automatic logic bin_in_window(input logic [BIN_W-1:0] bin,
                                         input logic [BIN_W-1:0] start,
                                         input logic [BIN_W-1:0] num);
    logic [BIN_W-1:0] offset;
    offset = bin - start;
    return offset < num;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; payload is frozen while valid && !ready.
module axis_out_reg
  import channelizer_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  beat_t beat_in,
  output logic  valid,
  input  logic  ready,
  output beat_t beat_out
);

  // Caller only pushes when the register is empty or draining this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      beat_out <= '0;
    end else if (push) begin
      valid    <= 1'b1;
      beat_out <= beat_in;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/channel_bin_selector.sv
// Forwards a configurable bin window of each channelizer frame and groups
// non-empty frames into packets, tagging a requested packet end with EOB.
module channel_bin_selector
  import channelizer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  cfg_start_bin,
  input  logic [BIN_W-1:0]  cfg_num_bins,
  input  logic [CNT_W-1:0]  cfg_frames_per_pkt,
  input  logic              eob_req,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [BIN_W-1:0]  s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [BIN_W-1:0]  m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              eob_tag,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t            state_q, state_d;
  logic              first_q;
  logic [BIN_W-1:0]  start_q, num_q;
  logic [CNT_W-1:0]  fpp_q, fip_q;
  logic              hold_v_q, hold_final_q, hold_last_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [BIN_W-1:0]  hold_bin_q;
  logic              eob_q;

  logic              out_valid;
  beat_t             out_beat, push_beat;
  logic              push;

  logic              s_fire, m_fire, in_run, out_free;
  logic [BIN_W-1:0]  eff_start, eff_num;
  logic [CNT_W-1:0]  eff_fpp, fpp_min1;
  logic [CNT_W:0]    fip_inc;
  logic              sel, pkt_end, frame_end, frame_has_sel, eob_clear;

  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign m_fire    = out_valid && m_axis_tready;
  assign out_free  = !out_valid || m_axis_tready;
  assign in_run    = (state_q == RUN);

  // Config in force for this beat: live inputs on a frame's first beat, latched copy after.
  assign eff_start = first_q ? cfg_start_bin      : start_q;
  assign eff_num   = first_q ? cfg_num_bins       : num_q;
  assign eff_fpp   = first_q ? cfg_frames_per_pkt : fpp_q;
  assign fpp_min1  = (eff_fpp == '0) ? CNT_W'(1) : eff_fpp;

  assign sel           = in_run && bin_in_window(s_axis_tuser, eff_start, eff_num);
  assign frame_end     = s_fire && s_axis_tlast && in_run;
  assign frame_has_sel = sel || (hold_v_q && !hold_final_q);
  assign fip_inc       = {1'b0, fip_q} + (CNT_W+1)'(1);
  assign pkt_end       = fip_inc >= {1'b0, fpp_min1};
  assign eob_clear     = m_fire && out_beat.last && out_beat.eob;

  // A held beat leaves when it is a frame's final beat or when the input displaces it.
  assign push = hold_v_q && out_free &&
                (hold_final_q || (s_fire && in_run && (sel || s_axis_tlast)));

  always_comb begin
    push_beat      = '0;
    push_beat.data = hold_data_q;
    push_beat.bin  = hold_bin_q;
    if (hold_final_q)
      push_beat.last = hold_last_q;
    else if (frame_end && !sel)
      push_beat.last = pkt_end;
    push_beat.eob  = push_beat.last && eob_q && !eob_clear;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && s_fire && s_axis_tlast) state_d = RUN;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (reset_n) begin
      case (state_q)
        SYNC:    s_axis_tready = 1'b1;
        RUN:     s_axis_tready = !(hold_v_q && !out_free);
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  // Hold slot, config latch, packet and frame counters, sticky EOB flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q      <= 1'b1;
      start_q      <= '0;
      num_q        <= '0;
      fpp_q        <= '0;
      fip_q        <= '0;
      hold_v_q     <= 1'b0;
      hold_final_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_bin_q   <= '0;
      eob_q        <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (s_fire) first_q <= s_axis_tlast;
      if (s_fire && first_q) begin
        start_q <= cfg_start_bin;
        num_q   <= cfg_num_bins;
        fpp_q   <= cfg_frames_per_pkt;
      end
      if (s_fire && sel) begin
        hold_v_q     <= 1'b1;
        hold_final_q <= s_axis_tlast;
        hold_last_q  <= s_axis_tlast && pkt_end;
        hold_data_q  <= s_axis_tdata;
        hold_bin_q   <= s_axis_tuser;
      end else if (push) begin
        hold_v_q     <= 1'b0;
        hold_final_q <= 1'b0;
      end
      if (frame_end && frame_has_sel)
        fip_q <= pkt_end ? '0 : fip_inc[CNT_W-1:0];
      eob_q <= eob_req || (eob_q && !eob_clear);
      if (s_fire && s_axis_tlast) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  axis_out_reg u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .beat_in  (push_beat),
    .valid    (out_valid),
    .ready    (m_axis_tready),
    .beat_out (out_beat)
  );

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tuser  = out_beat.bin;
  assign m_axis_tlast  = out_beat.last;
  assign eob_tag       = out_beat.eob;

endmodule

// File: tb/tb_channel_bin_selector.sv
// Directed bench for channel_bin_selector: window selection, packetisation, EOB, backpressure, reset.
module tb_channel_bin_selector;
  import channelizer_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [BIN_W-1:0]  cfg_start_bin, cfg_num_bins;
  logic [CNT_W-1:0]  cfg_frames_per_pkt;
  logic              eob_req;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [BIN_W-1:0]  s_axis_tuser;
  logic              s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [BIN_W-1:0]  m_axis_tuser;
  logic              m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic              eob_tag;
  logic [FCNT_W-1:0] frame_cnt;

  channel_bin_selector dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cfg_start_bin      (cfg_start_bin),
    .cfg_num_bins       (cfg_num_bins),
    .cfg_frames_per_pkt (cfg_frames_per_pkt),
    .eob_req            (eob_req),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .eob_tag            (eob_tag),
    .frame_cnt          (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BIN_W-1:0]  bin;
    logic              last;
    logic              eob;
  } rec_t;

  rec_t got[$];
  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   frame_no = 0;
  int   base;
  bit   rand_ready = 1'b0;
  bit   ready_low_seen = 1'b0;
  bit   prev_stall = 1'b0;
  logic [63:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records handshakes and checks payload stability under stall.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall)
        chk("axis_stall_stable",
            64'({m_axis_tvalid, m_axis_tlast, eob_tag, m_axis_tuser, m_axis_tdata}), prev_out);
      if (m_axis_tvalid && m_axis_tready)
        got.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast, eob_tag});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = 64'({m_axis_tvalid, m_axis_tlast, eob_tag, m_axis_tuser, m_axis_tdata});
      if (!s_axis_tready) ready_low_seen = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int lo, input int hi, input bit with_last, input int eob_bin);
    int guard;
    for (int b = lo; b <= hi; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {16'(frame_no), 16'(b)};
      s_axis_tuser  = BIN_W'(b);
      s_axis_tlast  = with_last && (b == hi);
      eob_req       = (b == eob_bin);
      guard = 0;
      @(negedge clk);
      while (!s_axis_tready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 1000) chk("s_ready_timeout", 64'(s_axis_tready), 64'(1));
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    eob_req       = 1'b0;
    if (with_last) frame_no++;
  endtask

  task automatic expect_beat(input int f, input int b, input bit last, input bit eob);
    exp_q.push_back('{{16'(f), 16'(b)}, BIN_W'(b), last, eob});
  endtask

  task automatic drain();
    int guard = 0;
    while (got.size() < exp_q.size() && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i),
          64'({got[i].eob, got[i].last, got[i].bin, got[i].data}),
          64'({exp_q[i].eob, exp_q[i].last, exp_q[i].bin, exp_q[i].data}));
    got.delete();
    exp_q.delete();
  endtask

  task automatic set_cfg(input int start, input int num, input int fpp);
    cfg_start_bin      = BIN_W'(start);
    cfg_num_bins       = BIN_W'(num);
    cfg_frames_per_pkt = CNT_W'(fpp);
  endtask

  task automatic expect_pkt_4_11(input int f0, input bit eob);
    for (int f = 0; f < 2; f++)
      for (int b = 4; b <= 11; b++)
        expect_beat(f0 + f, b, (f == 1) && (b == 11), eob && (f == 1) && (b == 11));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    chk({tag, "_tlast"},  64'(m_axis_tlast),  64'(0));
    chk({tag, "_tdata"},  64'(m_axis_tdata),  64'(0));
    chk({tag, "_tuser"},  64'(m_axis_tuser),  64'(0));
    chk({tag, "_eob"},    64'(eob_tag),       64'(0));
    chk({tag, "_fcnt"},   64'(frame_cnt),     64'(0));
    chk({tag, "_sready"}, 64'(s_axis_tready), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
    eob_req = 1'b0; m_axis_tready = 1'b1;
    set_cfg(0, 64, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("sync_ready", 64'(s_axis_tready), 64'(1));
    @(posedge clk); #1;

    // SYNC discards the first frame even with a wide-open window.
    send(0, 9, 1'b1, -1);
    drain();
    compare("sync_discard");
    chk("fcnt_sync", 64'(frame_cnt), 64'(1));

    // Case 1: bins 4..11 over two frames, tlast on second bin 11.
    set_cfg(4, 8, 2);
    base = frame_no;
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    expect_pkt_4_11(base, 1'b0);
    drain();
    compare("c1");
    chk("fcnt_c1", 64'(frame_cnt), 64'(3));

    // Case 2a: window 60..67 on a 64-bin frame keeps only 60..63.
    set_cfg(60, 8, 1);
    base = frame_no;
    send(0, 63, 1'b1, -1);
    for (int b = 60; b <= 63; b++) expect_beat(base, b, b == 63, 1'b0);
    drain();
    compare("c2a");

    // Case 2b: window wraps past bin 4095 to 0..3.
    set_cfg(4092, 8, 1);
    base = frame_no;
    send(0, 4095, 1'b1, -1);
    for (int b = 0; b <= 3; b++) expect_beat(base, b, 1'b0, 1'b0);
    for (int b = 4092; b <= 4095; b++) expect_beat(base, b, b == 4095, 1'b0);
    drain();
    compare("c2b");
    chk("fcnt_c2", 64'(frame_cnt), 64'(5));

    // Case 3: case 1 under random backpressure.
    set_cfg(4, 8, 2);
    rand_ready = 1'b1;
    base = frame_no;
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    expect_pkt_4_11(base, 1'b0);
    drain();
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    compare("c3");

    // Case 5: EOB pulse mid-packet tags only that packet's last beat.
    base = frame_no;
    send(0, 63, 1'b1, 30);
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    expect_pkt_4_11(base, 1'b1);
    expect_pkt_4_11(base + 2, 1'b0);
    drain();
    compare("c5");
    chk("fcnt_c5", 64'(frame_cnt), 64'(11));

    // Case 6: empty window passes nothing and never stalls the input.
    set_cfg(4, 0, 2);
    ready_low_seen = 1'b0;
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    drain();
    compare("c6");
    chk("c6_sready_low", 64'(ready_low_seen), 64'(0));
    chk("fcnt_c6", 64'(frame_cnt), 64'(13));

    // Case 4: reset mid-packet, resync, then a clean packet.
    set_cfg(4, 8, 2);
    send(0, 63, 1'b1, -1);
    send(0, 20, 1'b0, -1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    got.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(21, 63, 1'b1, -1);
    base = frame_no;
    send(0, 63, 1'b1, -1);
    send(0, 63, 1'b1, -1);
    expect_pkt_4_11(base, 1'b0);
    drain();
    compare("c4");
    chk("fcnt_c4", 64'(frame_cnt), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
